// File: rtl/word_packer.sv
// Assembles narrow fields into one wide word above a constant header.
// Output side is a registered valid/ready port; i_last closes a short word.
module word_packer #(
  parameter int unsigned          FIELD_W   = 8,
  parameter int unsigned          N_FIELDS  = 4,
  parameter int unsigned          HDR_W     = 16,
  parameter logic [HDR_W-1:0]     HDR       = 16'h3456,
  parameter logic [FIELD_W-1:0]   PAD       = '0,
  parameter bit                   MSB_FIRST = 1'b1,
  localparam int unsigned         WORD_W    = N_FIELDS*FIELD_W + HDR_W,
  localparam int unsigned         CNT_W     = $clog2(N_FIELDS+1)
) (
  input  logic               i_clk,
  input  logic               i_arst_n,
  input  logic [FIELD_W-1:0] i_field,
  input  logic               i_field_valid,
  input  logic               i_last,
  output logic               o_field_ready,
  output logic [WORD_W-1:0]  o_word,
  output logic [CNT_W-1:0]   o_count,
  output logic               o_word_valid,
  input  logic               i_word_ready
);

  localparam int unsigned SL_W = N_FIELDS*FIELD_W;

  if (FIELD_W == 0 || N_FIELDS == 0 || HDR_W == 0) begin : g_bad
    $error("word_packer: FIELD_W, N_FIELDS and HDR_W must be >= 1");
  end

  typedef enum logic {FILL, FULL} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SL_W-1:0]   slots_q, slots_d;

  logic             field_hs;
  logic             word_hs;
  logic [CNT_W-1:0] cnt_nxt;
  int               slot;
  int               first;

  assign o_field_ready = (state_q == FILL) || i_word_ready;
  assign field_hs      = i_field_valid && o_field_ready;
  assign word_hs       = (state_q == FULL) && i_word_ready;
  assign cnt_nxt       = cnt_q + CNT_W'(1);

  always_comb begin
    slots_d = slots_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    first   = MSB_FIRST ? int'(N_FIELDS) - 1 : 0;
    slot    = MSB_FIRST ? int'(N_FIELDS) - 1 - int'(cnt_q)
                        : int'(cnt_q);
    unique case (state_q)
      FILL: begin
        if (field_hs) begin
          for (int i = 0; i < int'(N_FIELDS); i++) begin
            if (i == slot) slots_d[i*FIELD_W +: FIELD_W] = i_field;
          end
          cnt_d = cnt_nxt;
          if (cnt_nxt == CNT_W'(N_FIELDS) || i_last) state_d = FULL;
        end
      end
      FULL: begin
        if (word_hs) begin
          slots_d = {N_FIELDS{PAD}};
          cnt_d   = '0;
          state_d = FILL;
          // Overlapped accept: the next word opens in the same cycle.
          if (field_hs) begin
            for (int i = 0; i < int'(N_FIELDS); i++) begin
              if (i == first) slots_d[i*FIELD_W +: FIELD_W] = i_field;
            end
            cnt_d = CNT_W'(1);
            if (N_FIELDS == 1 || i_last) state_d = FULL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      slots_q <= {N_FIELDS{PAD}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slots_q <= slots_d;
    end
  end

  assign o_word       = {slots_q, HDR};
  assign o_count      = cnt_q;
  assign o_word_valid = (state_q == FULL);

endmodule
